// File: rtl/fixpoint_pkg.sv
// Shared fixed-point constants for the MAC datapath: default operand,
// fraction and accumulator widths, plus the saturation bounds that the
// rounding stage clips results against.
package fixpoint_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam int DEFAULT_FRAC_BITS  = 8;
   localparam int DEFAULT_ACC_WIDTH  = 40;
   localparam int DEFAULT_LANES      = 4;

   // Largest representable signed value for a given result width.
   function automatic longint satMaxOf(input int dataWidth);
      return (64'sd1 <<< (dataWidth - 1)) - 64'sd1;
   endfunction

   // Most negative representable signed value for a given result width.
   function automatic longint satMinOf(input int dataWidth);
      return -(64'sd1 <<< (dataWidth - 1));
   endfunction

   localparam logic signed [DEFAULT_DATA_WIDTH-1:0] DEFAULT_SAT_MAX =
      DEFAULT_DATA_WIDTH'(satMaxOf(DEFAULT_DATA_WIDTH));
   localparam logic signed [DEFAULT_DATA_WIDTH-1:0] DEFAULT_SAT_MIN =
      DEFAULT_DATA_WIDTH'(satMinOf(DEFAULT_DATA_WIDTH));

endpackage

// File: rtl/mac_lane.sv
// One dot-product channel: operand register, exact signed product register,
// wide accumulator, and the round-half-up / saturate logic that turns the
// running sum into a DATA_WIDTH result. Pipeline advance and the first-beat
// decision come from the top level so every lane moves in lockstep.
module mac_lane
   import fixpoint_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int FRAC_BITS  = DEFAULT_FRAC_BITS,
   parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  advance,
   input  logic                  accEn,
   input  logic                  firstBeat,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  sat
);

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX    = ACC_WIDTH'(satMaxOf(DATA_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN    = ACC_WIDTH'(satMinOf(DATA_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(1) <<< (FRAC_BITS - 1);

   logic signed [DATA_WIDTH-1:0]   aReg;
   logic signed [DATA_WIDTH-1:0]   bReg;
   logic signed [2*DATA_WIDTH-1:0] product;
   logic signed [ACC_WIDTH-1:0]    acc;
   logic signed [ACC_WIDTH-1:0]    prodExt;
   logic signed [ACC_WIDTH-1:0]    accSum;
   logic signed [ACC_WIDTH-1:0]    rounded;
   logic signed [ACC_WIDTH-1:0]    shifted;

   // Operands, product and accumulator all move only when the whole pipe
   // advances. Both multiplicands are widened before the multiply so the
   // corner case of most-negative times most-negative stays exact. The
   // accumulator only changes for a valid beat reaching the last stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         aReg    <= '0;
         bReg    <= '0;
         product <= '0;
         acc     <= '0;
      end else if (advance) begin
         aReg    <= a;
         bReg    <= b;
         product <= (2*DATA_WIDTH)'(aReg) * (2*DATA_WIDTH)'(bReg);
         if (accEn) begin
            acc <= accSum;
         end
      end
   end

   // The next accumulator value either restarts from the product (first beat
   // of a vector) or adds to the running sum, wrapping within ACC_WIDTH.
   // That same value is rounded half toward +inf, shifted back to the result
   // scaling and clipped, so the last beat can be captured in one cycle.
   always_comb begin
      prodExt = ACC_WIDTH'(product);
      accSum  = firstBeat ? prodExt : acc + prodExt;
      rounded = accSum + ROUND_BIAS;
      shifted = rounded >>> FRAC_BITS;
      result  = shifted[DATA_WIDTH-1:0];
      sat     = 1'b0;
      if (shifted > SAT_MAX) begin
         result = SAT_MAX[DATA_WIDTH-1:0];
         sat    = 1'b1;
      end else if (shifted < SAT_MIN) begin
         result = SAT_MIN[DATA_WIDTH-1:0];
         sat    = 1'b1;
      end
   end

endmodule

// File: rtl/mac_fixpoint_pipe.sv
// Multi-lane fixed-point multiply-accumulate pipeline. Beats of per-lane
// operands are multiplied and summed until a beat flagged last, at which
// point each lane's rounded, saturated result is presented on a
// valid/ready output. Three register stages (operands, product,
// accumulate+output) all stall together whenever the output is blocked.
module mac_fixpoint_pipe
   import fixpoint_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int FRAC_BITS  = DEFAULT_FRAC_BITS,
   parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
   parameter int LANES      = DEFAULT_LANES
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        in_last,
   input  logic [LANES*DATA_WIDTH-1:0] a_in,
   input  logic [LANES*DATA_WIDTH-1:0] b_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DATA_WIDTH-1:0] out_data,
   output logic [LANES-1:0]            out_sat
);

   logic                        advance;
   logic                        accEn;
   logic                        s1Valid;
   logic                        s1Last;
   logic                        s2Valid;
   logic                        s2Last;
   logic                        firstBeat;
   logic [LANES*DATA_WIDTH-1:0] laneResult;
   logic [LANES-1:0]            laneSat;

   // The pipe can move whenever the output register is empty or being
   // drained this cycle; that one signal is both the upstream ready and the
   // global stage enable.
   always_comb begin
      advance  = !out_valid || out_ready;
      in_ready = advance;
      accEn    = advance && s2Valid;
   end

   // Valid/last tokens travel alongside the lane data. The first-beat flag
   // re-arms after every last beat so the next vector loads instead of adds,
   // and reset re-arms it so a partial vector is forgotten.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1Valid   <= 1'b0;
         s1Last    <= 1'b0;
         s2Valid   <= 1'b0;
         s2Last    <= 1'b0;
         firstBeat <= 1'b1;
      end else if (advance) begin
         s1Valid <= in_valid;
         s1Last  <= in_last;
         s2Valid <= s1Valid;
         s2Last  <= s1Last;
         if (s2Valid) begin
            firstBeat <= s2Last;
         end
      end
   end

   // The output register captures the lane results when a last beat
   // completes. If a result is draining in the same cycle the new one simply
   // replaces it and valid stays high; while stalled everything holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= '0;
      end else if (advance) begin
         if (s2Valid && s2Last) begin
            out_valid <= 1'b1;
            out_data  <= laneResult;
            out_sat   <= laneSat;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : genLane
      mac_lane #(
         .DATA_WIDTH(DATA_WIDTH),
         .FRAC_BITS (FRAC_BITS),
         .ACC_WIDTH (ACC_WIDTH)
      ) uLane (
         .clk      (clk),
         .rst      (rst),
         .advance  (advance),
         .accEn    (accEn),
         .firstBeat(firstBeat),
         .a        (a_in[i*DATA_WIDTH +: DATA_WIDTH]),
         .b        (b_in[i*DATA_WIDTH +: DATA_WIDTH]),
         .result   (laneResult[i*DATA_WIDTH +: DATA_WIDTH]),
         .sat      (laneSat[i])
      );
   end

endmodule

// File: tb/tb_mac_fixpoint_pipe.sv
// Directed self-checking bench for the fixed-point MAC pipeline with the
// default 16-bit, 8-fraction-bit, 4-lane configuration. Expected values are
// hand-computed constants.
module tb_mac_fixpoint_pipe;
   import fixpoint_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_last = 1'b0;
   logic [63:0] a_in = '0;
   logic [63:0] b_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_data;
   logic [3:0]  out_sat;

   int assertCount = 0;
   int failCount   = 0;
   int cycleCnt    = 0;

   typedef struct {
      logic [63:0] data;
      logic [3:0]  sat;
      int          cyc;
   } result_t;

   result_t resQ[$];

   mac_fixpoint_pipe #(
      .DATA_WIDTH(16),
      .FRAC_BITS (8),
      .ACC_WIDTH (40),
      .LANES     (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_last  (in_last),
      .a_in     (a_in),
      .b_in     (b_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_sat  (out_sat)
   );

   // Free-running clock and a cycle index used to measure latency.
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Record every output transfer mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         resQ.push_back('{out_data, out_sat, cycleCnt});
      end
   end

   // Present one beat and hold it until accepted; reports the cycle in which
   // it transferred.
   task automatic driveBeat(input logic [63:0] a, input logic [63:0] b,
                            input logic last, output int accCyc);
      bit ok = 1'b0;
      accCyc   = -1;
      a_in     = a;
      b_in     = b;
      in_last  = last;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         accCyc = cycleCnt;
         ok     = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      assertCount++;
      if (ok !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL beat_accept: got in_ready=%0b, expected 1 within 50 cycles", ok);
      end
   endtask

   // Pop the next recorded output, waiting a bounded number of cycles.
   task automatic getResult(output result_t r);
      bit got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         if (resQ.size() > 0) got = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      if (got) begin
         r = resQ.pop_front();
      end else begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL result_timeout: got no result, expected one within 50 cycles");
         r.data = 'x;
         r.sat  = 'x;
         r.cyc  = -1000;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      assertCount++;
      if (out_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      assertCount++;
      if (out_data !== 64'h0) begin
         failCount++;
         $display("[TB] FAIL reset_out_data: got %h expected 0", out_data);
      end
      assertCount++;
      if (out_sat !== 4'h0) begin
         failCount++;
         $display("[TB] FAIL reset_out_sat: got %b expected 0000", out_sat);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      assertCount++;
      if (in_ready !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_single_beat();
      int      accCyc;
      result_t r;
      driveBeat(64'h0180, 64'h0200, 1'b1, accCyc);
      getResult(r);
      assertCount++;
      if (r.data !== 64'h0000_0000_0000_0300) begin
         failCount++;
         $display("[TB] FAIL single_data: got %h expected 0000000000000300", r.data);
      end
      assertCount++;
      if (r.sat !== 4'b0000) begin
         failCount++;
         $display("[TB] FAIL single_sat: got %b expected 0000", r.sat);
      end
      assertCount++;
      if (r.cyc - accCyc !== 3) begin
         failCount++;
         $display("[TB] FAIL single_latency: got %0d expected 3", r.cyc - accCyc);
      end
   endtask

   task automatic test_rounding();
      logic [15:0] ra[4] = '{16'hFF00, 16'h0001, 16'h0001, 16'hFFFF};
      logic [15:0] rb[4] = '{16'h0080, 16'h0080, 16'h007F, 16'h0080};
      logic [15:0] re[4] = '{16'hFF80, 16'h0001, 16'h0000, 16'h0000};
      int          accCyc;
      result_t     r;
      logic [63:0] expData;
      for (int i = 0; i < 4; i++) begin
         expData = 64'(re[i]) << (16 * i);
         driveBeat(64'(ra[i]) << (16 * i), 64'(rb[i]) << (16 * i), 1'b1, accCyc);
         getResult(r);
         assertCount++;
         if (r.data !== expData) begin
            failCount++;
            $display("[TB] FAIL round_data_%0d: got %h expected %h", i, r.data, expData);
         end
         assertCount++;
         if (r.sat !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL round_sat_%0d: got %b expected 0000", i, r.sat);
         end
      end
   endtask

   task automatic test_saturation();
      int          accCyc;
      result_t     r;
      logic [63:0] expData;
      driveBeat(64'h8000, 64'h8000, 1'b1, accCyc);
      getResult(r);
      expData = 64'(DEFAULT_SAT_MAX);
      assertCount++;
      if (r.data !== expData) begin
         failCount++;
         $display("[TB] FAIL sat_pos_data: got %h expected %h", r.data, expData);
      end
      assertCount++;
      if (r.sat !== 4'b0001) begin
         failCount++;
         $display("[TB] FAIL sat_pos_flag: got %b expected 0001", r.sat);
      end
      for (int i = 0; i < 4; i++) begin
         driveBeat(64'h0000_8000_0000_0100, 64'h0000_7FFF_0000_0100, i == 3, accCyc);
      end
      getResult(r);
      expData = {16'h0000, DEFAULT_SAT_MIN, 32'h0000_0400};
      assertCount++;
      if (r.data !== expData) begin
         failCount++;
         $display("[TB] FAIL sat_neg_data: got %h expected %h", r.data, expData);
      end
      assertCount++;
      if (r.sat !== 4'b0100) begin
         failCount++;
         $display("[TB] FAIL sat_neg_flag: got %b expected 0100", r.sat);
      end
   endtask

   task automatic test_back_to_back();
      int      accCyc;
      result_t r1;
      result_t r2;
      driveBeat(64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 1'b0, accCyc);
      driveBeat(64'h0100_0100_0100_0100, 64'h0200_0200_0200_0200, 1'b0, accCyc);
      driveBeat(64'h0100_0100_0100_0100, 64'hFF00_FF00_FF00_FF00, 1'b1, accCyc);
      driveBeat(64'h0100_0100_0100_0100, 64'h0200_0100_0080_0040, 1'b0, accCyc);
      driveBeat(64'h0100_0100_0100_0100, 64'h0200_0100_0080_0040, 1'b1, accCyc);
      getResult(r1);
      getResult(r2);
      assertCount++;
      if (r1.data !== 64'h0200_0200_0200_0200 || r1.sat !== 4'b0000) begin
         failCount++;
         $display("[TB] FAIL b2b_first: got %h/%b expected 0200020002000200/0000", r1.data, r1.sat);
      end
      assertCount++;
      if (r2.data !== 64'h0400_0200_0100_0080 || r2.sat !== 4'b0000) begin
         failCount++;
         $display("[TB] FAIL b2b_second: got %h/%b expected 0400020001000080/0000", r2.data, r2.sat);
      end
      assertCount++;
      if (r2.cyc - r1.cyc !== 2) begin
         failCount++;
         $display("[TB] FAIL b2b_spacing: got %0d expected 2", r2.cyc - r1.cyc);
      end
      repeat (5) @(posedge clk);
      #1;
      assertCount++;
      if (resQ.size() !== 0) begin
         failCount++;
         $display("[TB] FAIL b2b_extra_results: got %0d expected 0", resQ.size());
      end
   endtask

   task automatic test_backpressure();
      int          accCyc;
      result_t     r;
      logic [63:0] expSeq[4] = '{64'h0300, 64'h0200, 64'h0100, 64'h0400};
      out_ready = 1'b0;
      driveBeat(64'h0100, 64'h0300, 1'b1, accCyc);
      driveBeat(64'h0100, 64'h0200, 1'b1, accCyc);
      driveBeat(64'h0100, 64'h0100, 1'b1, accCyc);
      a_in     = 64'h0100;
      b_in     = 64'h0400;
      in_last  = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         assertCount++;
         if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 64'h0300}) begin
            failCount++;
            $display("[TB] FAIL stall_hold_%0d: got in_ready=%b out_valid=%b data=%h expected 0/1/0000000000000300",
                     i, in_ready, out_valid, out_data);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      driveBeat(64'h0100, 64'h0400, 1'b1, accCyc);
      for (int i = 0; i < 4; i++) begin
         getResult(r);
         assertCount++;
         if (r.data !== expSeq[i] || r.sat !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL stall_result_%0d: got %h/%b expected %h/0000", i, r.data, r.sat, expSeq[i]);
         end
      end
   endtask

   task automatic test_reset_mid_vector();
      int      accCyc;
      result_t r;
      driveBeat(64'h0100, 64'h0300, 1'b0, accCyc);
      driveBeat(64'h0100, 64'h0300, 1'b0, accCyc);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      resQ.delete();
      driveBeat(64'h0100, 64'h0100, 1'b1, accCyc);
      getResult(r);
      assertCount++;
      if (r.data !== 64'h0100) begin
         failCount++;
         $display("[TB] FAIL mid_reset_data: got %h expected 0000000000000100", r.data);
      end
      assertCount++;
      if (r.sat !== 4'b0000) begin
         failCount++;
         $display("[TB] FAIL mid_reset_sat: got %b expected 0000", r.sat);
      end
   endtask

   initial begin
      $display("[TB] starting mac_fixpoint_pipe bench");
      test_reset();
      test_single_beat();
      test_rounding();
      test_saturation();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_vector();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
